pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter EXC_MRET, default 32'h0000000e, excepttype_i code that selects mepc_i as the redirect target.
REQ-002 SHALL have parameter PERF_W, default 32, width of the stall-cycle counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stallreq_if  input  1  IF stage stall request.
REQ-006 stallreq_id  input  1  ID stage stall request.
REQ-007 stallreq_ex  input  1  EX stage stall request.
REQ-008 stallreq_mem  input  1  MEM stage stall request.
REQ-009 excepttype_i  input  32  exception code from MEM; nonzero means an exception.
REQ-010 mepc_i  input  32  return address for EXC_MRET.
REQ-011 mtvec_i  input  32  trap vector base.
REQ-012 ex_branch_flag_real  input  1  resolved branch/jump taken in EX.
REQ-013 ex_branch_tar_addr_real  input  32  resolved branch target.
REQ-014 perf_clr  input  1  clears the stall counter.
REQ-015 stall  output  6  per-stage hold: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB.
REQ-016 flush  output  1  squash all pipeline registers, one cycle.
REQ-017 branch_flush  output  1  squash IF/ID only.
REQ-018 new_pc  output  32  PC redirect target, valid when flush or branch_flush is 1.
REQ-019 perf_stall_cnt  output  PERF_W  count of cycles with stall != 0.

Function
REQ-020 Stall encoding SHALL be combinational by priority mem > ex > id > if: 6'b011111, 6'b001111, 6'b000111, 6'b000011; none gives 6'b000000.
REQ-021 FSM SHALL have states RUN, FLUSH, REFILL, with state, flush and new_pc registered.
REQ-022 RUN: excepttype_i != 0 SHALL move to FLUSH next cycle; otherwise stay in RUN.
REQ-023 Entering FLUSH SHALL register new_pc = mepc_i if excepttype_i == EXC_MRET, else mtvec_i.
REQ-024 FLUSH SHALL last exactly one cycle with flush = 1, then go to REFILL.
REQ-025 In FLUSH the stall output SHALL be forced to 6'b000000 regardless of requests.
REQ-026 REFILL SHALL last one cycle with flush = 0, excepttype_i ignored, then go to RUN.
REQ-026a The REFILL masking prevents retriggering from the squashed bubble.
REQ-027 branch_flush SHALL be combinational: 1 iff state == RUN, ex_branch_flag_real == 1, and stall[3] == 0.
REQ-028 When branch_flush = 1, new_pc SHALL equal ex_branch_tar_addr_real in the same cycle, muxed over the registered value.
REQ-029 An exception SHALL win over a simultaneous branch: FLUSH target is used next cycle and branch_flush is not asserted in FLUSH or REFILL.
REQ-030 perf_stall_cnt SHALL increment by 1 each cycle with stall != 0 and wrap modulo 2^PERF_W.
REQ-031 perf_clr SHALL zero the counter next cycle and take priority over increment.
REQ-032 stall, branch_flush and new_pc SHALL depend on the requests with zero latency; flush SHALL have one-cycle latency from exception detection.

Reset
REQ-033 rst = 1 at a clock edge SHALL set state = RUN, flush = 0, new_pc = 32'h0, perf_stall_cnt = 0.
REQ-034 Reset SHALL take priority over every other event, including an in-progress FLUSH or REFILL, which it aborts.
REQ-035 While rst = 1, stall SHALL read 6'b000000 and branch_flush SHALL read 0.

Verification
REQ-036 stallreq_id=1 and stallreq_mem=1 in RUN -> stall = 6'b011111; perf_stall_cnt +1 per cycle.
REQ-037 excepttype_i = 32'h00000008, mtvec_i = 32'h00000100 at cycle N -> flush = 1 and new_pc = 32'h00000100 in cycle N+1 only; flush = 0 in N+2; RUN in N+3.
REQ-038 excepttype_i = 32'h0000000e, mepc_i = 32'h00000040 -> new_pc = 32'h00000040 during flush.
REQ-039 ex_branch_flag_real=1, tar = 32'h00000080, no stall -> branch_flush = 1 and new_pc = 32'h00000080 same cycle; with stallreq_ex=1 -> branch_flush = 0.
REQ-040 Exception and branch in the same cycle -> no branch_flush; flush with trap target next cycle; excepttype_i held nonzero through REFILL causes no second flush.
REQ-041 rst asserted during FLUSH -> next cycle flush = 0, state RUN, counter 0; counter at all-ones plus a stall cycle -> wraps to 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline control: per-stage stall encoding, exception flush sequencing
// (RUN -> FLUSH -> REFILL -> RUN), branch redirect and a stall-cycle counter.
module pipe_ctrl #(
  parameter logic [31:0] EXC_MRET = 32'h0000000e,
  parameter int unsigned PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic [31:0]       excepttype_i,
  input  logic [31:0]       mepc_i,
  input  logic [31:0]       mtvec_i,
  input  logic              ex_branch_flag_real,
  input  logic [31:0]       ex_branch_tar_addr_real,
  input  logic              perf_clr,
  output logic [5:0]        stall,
  output logic              flush,
  output logic              branch_flush,
  output logic [31:0]       new_pc,
  output logic [PERF_W-1:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    REFILL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              flush_q, flush_d;
  logic [31:0]       new_pc_q, new_pc_d;
  logic [PERF_W-1:0] cnt_q;

  // Stall priority encoder; held off during reset and while the pipe is squashed.
  always_comb begin
    stall = '0;
    if (!rst && state_q != FLUSH) begin
      if (stallreq_mem)     stall = 6'b011111;
      else if (stallreq_ex) stall = 6'b001111;
      else if (stallreq_id) stall = 6'b000111;
      else if (stallreq_if) stall = 6'b000011;
    end
  end

  // Branch redirect only from a running, unstalled EX stage.
  always_comb begin
    branch_flush = !rst && (state_q == RUN) && ex_branch_flag_real && !stall[3];
  end

  // Branch target overrides the registered trap target in the same cycle.
  always_comb begin
    new_pc = branch_flush ? ex_branch_tar_addr_real : new_pc_q;
    flush  = flush_q;
    perf_stall_cnt = cnt_q;
  end

  // Next-state logic; REFILL ignores exceptions so the squashed bubble cannot retrigger.
  always_comb begin
    state_d  = state_q;
    new_pc_d = new_pc_q;
    case (state_q)
      RUN: begin
        if (excepttype_i != '0) begin
          state_d  = FLUSH;
          new_pc_d = (excepttype_i == EXC_MRET) ? mepc_i : mtvec_i;
        end
      end
      FLUSH:   state_d = REFILL;
      REFILL:  state_d = RUN;
      default: state_d = RUN;
    endcase
    flush_d = (state_d == FLUSH);
  end

  // State, flush and trap target registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      flush_q  <= 1'b0;
      new_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      new_pc_q <= new_pc_d;
    end
  end

  // Stall-cycle counter; clear wins over increment, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) cnt_q <= '0;
    else if (stall != '0) cnt_q <= cnt_q + PERF_W'(1);
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (4-bit counter instance to reach wrap quickly).
module tb_pipe_ctrl;

  localparam int unsigned PW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0]   excepttype_i, mepc_i, mtvec_i, ex_branch_tar_addr_real;
  logic          ex_branch_flag_real, perf_clr;
  logic [5:0]    stall;
  logic          flush, branch_flush;
  logic [31:0]   new_pc;
  logic [PW-1:0] perf_stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.EXC_MRET(32'h0000000e), .PERF_W(PW)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype_i(excepttype_i), .mepc_i(mepc_i), .mtvec_i(mtvec_i),
    .ex_branch_flag_real(ex_branch_flag_real),
    .ex_branch_tar_addr_real(ex_branch_tar_addr_real),
    .perf_clr(perf_clr),
    .stall(stall), .flush(flush), .branch_flush(branch_flush),
    .new_pc(new_pc), .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
    excepttype_i = '0; mepc_i = '0; mtvec_i = '0;
    ex_branch_flag_real = 0; ex_branch_tar_addr_real = '0; perf_clr = 0;

    // Reset state and reset masking
    tick(); tick();
    stallreq_mem = 1; ex_branch_flag_real = 1; ex_branch_tar_addr_real = 32'h80;
    #1;
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_bflush", 32'(branch_flush), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    chk("rst_newpc", new_pc, 32'h0);
    chk("rst_cnt", 32'(perf_stall_cnt), 32'h0);
    tick();
    chk("rst_cnt2", 32'(perf_stall_cnt), 32'h0);
    stallreq_mem = 0; ex_branch_flag_real = 0;
    rst = 1'b0;
    tick();

    // Stall priority and counting
    stallreq_id = 1; stallreq_mem = 1; #1;
    chk("stall_mem_id", 32'(stall), 32'h1f);
    tick(); tick();
    chk("cnt_2", 32'(perf_stall_cnt), 32'h2);
    stallreq_mem = 0; stallreq_ex = 1; #1;
    chk("stall_ex", 32'(stall), 32'h0f);
    stallreq_ex = 0; #1;
    chk("stall_id", 32'(stall), 32'h07);
    stallreq_id = 0; stallreq_if = 1; #1;
    chk("stall_if", 32'(stall), 32'h03);
    stallreq_if = 0; #1;
    chk("stall_none", 32'(stall), 32'h00);
    tick();
    chk("cnt_hold", 32'(perf_stall_cnt), 32'h2);
    perf_clr = 1; stallreq_mem = 1;
    tick();
    chk("cnt_clr", 32'(perf_stall_cnt), 32'h0);
    perf_clr = 0; stallreq_mem = 0;

    // Trap to mtvec: flush one cycle, then REFILL, then RUN
    excepttype_i = 32'h8; mtvec_i = 32'h100;
    tick();
    excepttype_i = '0; stallreq_mem = 1; #1;
    chk("trap_flush", 32'(flush), 32'h1);
    chk("trap_newpc", new_pc, 32'h100);
    chk("flush_stall0", 32'(stall), 32'h0);
    stallreq_mem = 0;
    tick();
    ex_branch_flag_real = 1; #1;
    chk("refill_flush", 32'(flush), 32'h0);
    chk("refill_newpc", new_pc, 32'h100);
    chk("refill_bflush", 32'(branch_flush), 32'h0);
    chk("cnt_flush", 32'(perf_stall_cnt), 32'h0);
    tick();
    chk("run_bflush", 32'(branch_flush), 32'h1);

    // Branch redirect in RUN
    chk("br_newpc", new_pc, 32'h80);
    stallreq_ex = 1; #1;
    chk("br_ex_stall", 32'(branch_flush), 32'h0);
    chk("br_ex_newpc", new_pc, 32'h100);
    stallreq_ex = 0; stallreq_mem = 1; #1;
    chk("br_mem_stall", 32'(branch_flush), 32'h0);
    stallreq_mem = 0; ex_branch_flag_real = 0;

    // MRET uses mepc
    excepttype_i = 32'he; mepc_i = 32'h40;
    tick();
    excepttype_i = '0;
    chk("mret_flush", 32'(flush), 32'h1);
    chk("mret_newpc", new_pc, 32'h40);
    tick(); tick();

    // Exception beats simultaneous branch; held exception ignored in REFILL
    excepttype_i = 32'h8; mtvec_i = 32'h200;
    ex_branch_flag_real = 1; ex_branch_tar_addr_real = 32'h80;
    tick();
    chk("xb_flush", 32'(flush), 32'h1);
    chk("xb_newpc", new_pc, 32'h200);
    chk("xb_bflush_f", 32'(branch_flush), 32'h0);
    tick();
    chk("xb_refill_flush", 32'(flush), 32'h0);
    chk("xb_bflush_r", 32'(branch_flush), 32'h0);
    tick();
    chk("xb_no_reflush", 32'(flush), 32'h0);
    excepttype_i = '0; ex_branch_flag_real = 0;
    tick();
    chk("xb_run_flush", 32'(flush), 32'h0);

    // Reset aborts FLUSH
    stallreq_mem = 1;
    tick();
    chk("pre_rst_cnt", 32'(perf_stall_cnt), 32'h1);
    stallreq_mem = 0; excepttype_i = 32'h8; mtvec_i = 32'h300;
    tick();
    chk("pre_rst_flush", 32'(flush), 32'h1);
    excepttype_i = '0; rst = 1;
    tick();
    chk("abort_flush", 32'(flush), 32'h0);
    chk("abort_cnt", 32'(perf_stall_cnt), 32'h0);
    chk("abort_newpc", new_pc, 32'h0);
    rst = 0;
    tick();
    ex_branch_flag_real = 1; ex_branch_tar_addr_real = 32'h84; #1;
    chk("abort_run", 32'(branch_flush), 32'h1);
    ex_branch_flag_real = 0;

    // Counter wrap
    stallreq_mem = 1;
    for (int i = 0; i < 15; i++) tick();
    chk("cnt_max", 32'(perf_stall_cnt), 32'hf);
    tick();
    chk("cnt_wrap", 32'(perf_stall_cnt), 32'h0);
    stallreq_mem = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
